// File: rtl/uart_job_framer_if.sv
// Byte-stream in, validated hashing job out, plus error strobe and job counter.
// The framer connects through the slave modport; the UART/hasher side uses master.
interface uart_job_framer_if;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  out_data;
  logic [255:0] out_state;
  logic [255:0] out_target;
  logic [31:0]  out_position;
  logic [31:0]  out_nonce_base;
  logic         err_valid;
  logic [1:0]   err_code;
  logic [15:0]  stat_jobs;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_state, out_target,
           out_position, out_nonce_base, err_valid, err_code, stat_jobs
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_state, out_target,
           out_position, out_nonce_base, err_valid, err_code, stat_jobs
  );
endinterface

// File: rtl/uart_job_framer.sv
// Hunts for a sync byte, assembles an 84-byte XOR-protected work packet and
// presents it to the hasher on a valid/ready handshake; bad frames strobe an error.
module uart_job_framer #(
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic              clk,
  input  logic              rstn,
  uart_job_framer_if.slave  bus
);

  localparam int PAYLOAD_BYTES = 84;
  localparam int TW            = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]    IDX_LAST   = 7'(PAYLOAD_BYTES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  localparam logic [1:0] ERR_SYNC    = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [6:0]    idx_reg, idx_next;
  logic [7:0]    csum_reg, csum_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          err_valid_reg, err_valid_next;
  logic [1:0]    err_code_reg, err_code_next;
  logic [15:0]   stat_jobs_reg, stat_jobs_next;
  logic [7:0]    payload_reg [PAYLOAD_BYTES];

  logic accept;
  logic in_frame;
  logic timeout_hit;
  logic payload_we;

  assign accept      = bus.in_valid && (state_reg != ST_HOLD);
  assign in_frame    = (state_reg == ST_PAYLOAD) || (state_reg == ST_CHECK);
  // An accepted byte in the threshold cycle wins over the timeout.
  assign timeout_hit = in_frame && !accept && (timer_reg == TIMER_LAST);
  assign payload_we  = (state_reg == ST_PAYLOAD) && accept;

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    csum_next      = csum_reg;
    stat_jobs_next = stat_jobs_reg;
    err_valid_next = 1'b0;
    err_code_next  = 2'd0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (bus.in_data == SYNC_BYTE) begin
            idx_next   = '0;
            csum_next  = '0;
            state_next = ST_PAYLOAD;
          end else begin
            err_valid_next = 1'b1;
            err_code_next  = ERR_SYNC;
          end
        end
      end
      ST_PAYLOAD: begin
        // Sync-valued bytes here are plain data; no mid-frame resync.
        if (accept) begin
          csum_next = csum_reg ^ bus.in_data;
          idx_next  = idx_reg + 7'd1;
          if (idx_reg == IDX_LAST) begin
            state_next = ST_CHECK;
          end
        end else if (timeout_hit) begin
          err_valid_next = 1'b1;
          err_code_next  = ERR_TIMEOUT;
          state_next     = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (accept) begin
          if (bus.in_data == csum_reg) begin
            state_next = ST_HOLD;
          end else begin
            err_valid_next = 1'b1;
            err_code_next  = ERR_CSUM;
            state_next     = ST_IDLE;
          end
        end else if (timeout_hit) begin
          err_valid_next = 1'b1;
          err_code_next  = ERR_TIMEOUT;
          state_next     = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_next     = ST_IDLE;
          stat_jobs_next = stat_jobs_reg + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Idle-cycle counter runs only inside a frame and restarts on every byte.
  always_comb begin
    timer_next = '0;
    if (in_frame && !accept && !timeout_hit) begin
      timer_next = timer_reg + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      csum_reg      <= '0;
      timer_reg     <= '0;
      err_valid_reg <= 1'b0;
      err_code_reg  <= 2'd0;
      stat_jobs_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      csum_reg      <= csum_next;
      timer_reg     <= timer_next;
      err_valid_reg <= err_valid_next;
      err_code_reg  <= err_code_next;
      stat_jobs_reg <= stat_jobs_next;
    end
  end

  // Payload bytes land directly in the job registers; frozen outside PAYLOAD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < PAYLOAD_BYTES; k++) begin
        payload_reg[k] <= '0;
      end
    end else if (payload_we) begin
      for (int k = 0; k < PAYLOAD_BYTES; k++) begin
        if (idx_reg == 7'(k)) begin
          payload_reg[k] <= bus.in_data;
        end
      end
    end
  end

  logic [95:0]  data_w;
  logic [255:0] state_w;
  logic [255:0] target_w;
  logic [31:0]  position_w;
  logic [31:0]  nonce_w;

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_data
      assign data_w[8*gi +: 8] = payload_reg[gi];
    end
    // Midstate words arrive big-endian: first byte of a word is its MSB.
    for (gi = 0; gi < 32; gi++) begin : g_state
      assign state_w[32*(gi/4) + 8*(3-(gi%4)) +: 8] = payload_reg[12+gi];
    end
    for (gi = 0; gi < 32; gi++) begin : g_target
      assign target_w[8*gi +: 8] = payload_reg[44+gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_tail
      assign position_w[8*gi +: 8] = payload_reg[76+gi];
      assign nonce_w[8*gi +: 8]    = payload_reg[80+gi];
    end
  endgenerate

  assign bus.in_ready       = (state_reg != ST_HOLD);
  assign bus.out_valid      = (state_reg == ST_HOLD);
  assign bus.out_data       = data_w;
  assign bus.out_state      = state_w;
  assign bus.out_target     = target_w;
  assign bus.out_position   = position_w;
  assign bus.out_nonce_base = nonce_w;
  assign bus.err_valid      = err_valid_reg;
  assign bus.err_code       = err_code_reg;
  assign bus.stat_jobs      = stat_jobs_reg;

endmodule

// File: tb/tb_uart_job_framer.sv
// Directed bench: table of whole-frame vectors plus hand sequences for
// backpressure, timeout threshold and reset during HOLD.
module tb_uart_job_framer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_job_framer_if bus ();

  uart_job_framer #(.TIMEOUT_CYCLES(16), .SYNC_BYTE(8'hA5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int          id;
    bit          send_junk;
    logic [7:0]  junk;
    logic [7:0]  seed;
    logic [7:0]  step;
    bit          corrupt;
    bit          exp_job;
    logic [1:0]  exp_err;
    logic [7:0]  exp_d0;
    logic [31:0] exp_w0;
    logic [31:0] exp_pos;
    logic [31:0] exp_nonce;
    logic [15:0] exp_stat;
  } vec_t;

  vec_t vecs [5];

  int checks = 0;
  int errors = 0;
  int exp_jobs = 0;
  int dbl_err = 0;
  int bad_code = 0;
  logic prev_err = 1'b0;
  logic [1:0] err_log [$];
  logic [7:0] pay [84];

  logic [95:0]  m_data;
  logic [255:0] m_state;
  logic [255:0] m_target;
  logic [31:0]  m_pos;
  logic [31:0]  m_nonce;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Error strobe monitor: logs codes, flags multi-cycle strobes and stray codes.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.err_valid) err_log.push_back(bus.err_code);
      if (bus.err_valid && prev_err) dbl_err++;
      if (!bus.err_valid && bus.err_code != 2'd0) bad_code++;
      prev_err = bus.err_valid;
    end else begin
      prev_err = 1'b0;
    end
  end

  task automatic fill(input logic [7:0] seed, input logic [7:0] step);
    for (int k = 0; k < 84; k++) pay[k] = 8'(int'(seed) + int'(step) * k);
    m_data = '0; m_state = '0; m_target = '0; m_pos = '0; m_nonce = '0;
    for (int k = 0; k < 12; k++) m_data[8*k +: 8] = pay[k];
    for (int k = 12; k < 44; k++) m_state[32*((k-12)/4) + 8*(3-((k-12)%4)) +: 8] = pay[k];
    for (int k = 44; k < 76; k++) m_target[8*(k-44) +: 8] = pay[k];
    for (int k = 76; k < 80; k++) m_pos[8*(k-76) +: 8] = pay[k];
    for (int k = 80; k < 84; k++) m_nonce[8*(k-80) +: 8] = pay[k];
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    chk("in_ready_for_byte", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_range(input int from, input int upto);
    for (int k = from; k <= upto; k++) send_byte(pay[k]);
  endtask

  task automatic send_csum(input bit corrupt);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < 84; k++) c ^= pay[k];
    if (corrupt) c ^= 8'h01;
    send_byte(c);
  endtask

  task automatic check_job(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b1);
    chk({tag, "_in_ready_hold"}, bus.in_ready, 1'b0);
    chk({tag, "_out_data"}, bus.out_data, m_data);
    chk({tag, "_out_state"}, bus.out_state, m_state);
    chk({tag, "_out_target"}, bus.out_target, m_target);
    chk({tag, "_out_position"}, bus.out_position, m_pos);
    chk({tag, "_out_nonce"}, bus.out_nonce_base, m_nonce);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    exp_jobs++;
    @(negedge clk);
    chk({tag, "_valid_drop"}, bus.out_valid, 1'b0);
    chk({tag, "_in_ready_after"}, bus.in_ready, 1'b1);
    chk({tag, "_stat_jobs"}, bus.stat_jobs, 16'(exp_jobs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int early;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    vecs[0] = '{0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1, 2'd0, 8'h00, 32'h0C0D0E0F, 32'h4F4E4D4C, 32'h53525150, 16'd1};
    vecs[1] = '{1, 1'b1, 8'h3C, 8'h10, 8'h02, 1'b0, 1'b1, 2'd1, 8'h10, 32'h282A2C2E, 32'hAEACAAA8, 32'hB6B4B2B0, 16'd2};
    vecs[2] = '{2, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 2'd2, 8'h00, 32'h0,        32'h0,        32'h0,        16'd2};
    vecs[3] = '{3, 1'b0, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b1, 2'd0, 8'hA5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'd3};
    vecs[4] = '{4, 1'b1, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1, 2'd1, 8'hFF, 32'hF3F2F1F0, 32'hB0B1B2B3, 32'hACADAEAF, 16'd4};

    // Reset state
    #2;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_err_valid", bus.err_valid, 1'b0);
    chk("rst_err_code", bus.err_code, 2'd0);
    chk("rst_stat_jobs", bus.stat_jobs, 16'd0);
    chk("rst_out_state", bus.out_state, 256'd0);
    chk("rst_out_position", bus.out_position, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven frames
    foreach (vecs[i]) begin
      err_log.delete();
      fill(vecs[i].seed, vecs[i].step);
      $display("vector %0d seed=%h step=%h junk=%0d corrupt=%0d", vecs[i].id, vecs[i].seed, vecs[i].step, vecs[i].send_junk, vecs[i].corrupt);
      if (vecs[i].send_junk) send_byte(vecs[i].junk);
      send_byte(8'hA5);
      send_range(0, 83);
      send_csum(vecs[i].corrupt);
      bus.in_valid = 1'b0;
      if (vecs[i].exp_job) begin
        check_job($sformatf("v%0d", vecs[i].id));
        chk($sformatf("v%0d_data0", vecs[i].id), bus.out_data[7:0], vecs[i].exp_d0);
        chk($sformatf("v%0d_state_w0", vecs[i].id), bus.out_state[31:0], vecs[i].exp_w0);
        chk($sformatf("v%0d_position", vecs[i].id), bus.out_position, vecs[i].exp_pos);
        chk($sformatf("v%0d_nonce", vecs[i].id), bus.out_nonce_base, vecs[i].exp_nonce);
        handshake($sformatf("v%0d", vecs[i].id));
      end else begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk($sformatf("v%0d_no_job", vecs[i].id), bus.out_valid, 1'b0);
        end
      end
      chk($sformatf("v%0d_stat_table", vecs[i].id), bus.stat_jobs, vecs[i].exp_stat);
      chk($sformatf("v%0d_err_count", vecs[i].id), err_log.size(), (vecs[i].exp_err != 2'd0) ? 1 : 0);
      if (err_log.size() > 0 && vecs[i].exp_err != 2'd0)
        chk($sformatf("v%0d_err_code", vecs[i].id), err_log[0], vecs[i].exp_err);
    end

    // Backpressure: job held 500 cycles with a sync byte waiting
    err_log.delete();
    fill(8'h00, 8'h01);
    $display("sequence backpressure");
    send_byte(8'hA5);
    send_range(0, 83);
    send_csum(1'b0);
    bus.in_data = 8'hA5;
    check_job("bp");
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== m_data ||
          bus.out_state !== m_state || bus.out_target !== m_target ||
          bus.out_position !== m_pos || bus.out_nonce_base !== m_nonce) bad++;
    end
    chk("bp_stable_cycles_bad", bad, 0);
    handshake("bp");
    @(posedge clk);
    #1;
    send_range(0, 83);
    send_csum(1'b0);
    bus.in_valid = 1'b0;
    check_job("bp_next");
    handshake("bp_next");
    chk("bp_err_count", err_log.size(), 0);

    // Timeout after P40: error strobe 16 cycles after the last accepted byte
    err_log.delete();
    $display("sequence timeout");
    send_byte(8'hA5);
    send_range(0, 40);
    bus.in_valid = 1'b0;
    early = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus.err_valid) early++;
    end
    chk("to_no_early_err", early, 0);
    @(negedge clk);
    chk("to_err_valid", bus.err_valid, 1'b1);
    chk("to_err_code", bus.err_code, 2'd3);
    @(negedge clk);
    chk("to_err_one_cycle", bus.err_valid, 1'b0);
    chk("to_err_count", err_log.size(), 1);

    // Byte arriving in the threshold cycle cancels the timeout
    err_log.delete();
    $display("sequence timeout_threshold_byte");
    send_byte(8'hA5);
    send_range(0, 40);
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    send_range(41, 83);
    send_csum(1'b0);
    bus.in_valid = 1'b0;
    check_job("thr");
    handshake("thr");
    chk("thr_err_count", err_log.size(), 0);

    // Reset during HOLD drops the job asynchronously
    err_log.delete();
    $display("sequence reset_in_hold");
    send_byte(8'hA5);
    send_range(0, 83);
    send_csum(1'b0);
    bus.in_valid = 1'b0;
    check_job("rh");
    #2 rstn = 1'b0;
    #1;
    chk("rh_out_valid", bus.out_valid, 1'b0);
    chk("rh_in_ready", bus.in_ready, 1'b1);
    chk("rh_stat_jobs", bus.stat_jobs, 16'd0);
    chk("rh_err_valid", bus.err_valid, 1'b0);
    chk("rh_out_position", bus.out_position, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    exp_jobs = 0;
    send_byte(8'hA5);
    send_range(0, 83);
    send_csum(1'b0);
    bus.in_valid = 1'b0;
    check_job("post_rst");
    handshake("post_rst");
    chk("rh_err_count", err_log.size(), 0);

    chk("err_strobe_multi_cycle", dbl_err, 0);
    chk("err_code_without_valid", bad_code, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_job_framer.md
# uart_job_framer

Byte-stream framer between the UART receiver and the SHA-256 hashing array. It hunts for a sync byte and assembles an 84-byte work packet protected by an XOR checksum. A validated job is presented to the hasher on a valid/ready handshake. Malformed, corrupted or stalled frames are dropped and reported on a one-cycle error strobe.

## Interface
- TIMEOUT_CYCLES, 1_000_000, idle cycles allowed between bytes inside a frame (10 ms at 100 MHz); must be ≥ 2
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous, active-low
- in_valid  in  1  byte available from UART receiver
- in_data  in  8  received byte
- in_ready  out  1  framer accepts byte; a byte transfers when in_valid && in_ready
- out_valid  out  1  complete validated job present
- out_ready  in  1  hasher takes job; job transfers when out_valid && out_ready
- out_data  out  96  12 message-tail bytes
- out_state  out  256  8 × 32-bit midstate words
- out_target  out  256  32 target bytes
- out_position  out  32  nonce byte position
- out_nonce_base  out  32  starting nonce
- err_valid  out  1  one-cycle error strobe
- err_code  out  2  error cause: 1 bad sync, 2 checksum, 3 timeout; 0 when err_valid is low
- stat_jobs  out  16  count of delivered jobs

## Operation
- Frame format: SYNC_BYTE, payload bytes P0..P83, checksum byte C; 86 bytes total. C equals the XOR of P0..P83.
- Payload mapping (k = payload index):
  - k 0–11 → out_data[8k +: 8]
  - k 12–43: let w = (k−12)/4 and b = (k−12)%4; → out_state[32w + 8(3−b) +: 8] (words are big-endian on the wire)
  - k 44–75 → out_target[8(k−44) +: 8]
  - k 76–79 → out_position[8(k−76) +: 8] (little-endian)
  - k 80–83 → out_nonce_base[8(k−80) +: 8] (little-endian)
- Payload bytes are written directly into the out_* registers. out_* content is defined only while out_valid = 1.
- State machine:
  - IDLE: in_ready = 1. A byte equal to SYNC_BYTE clears the index and checksum, then goes to PAYLOAD. Any other byte is discarded and pulses err_code = 1.
  - PAYLOAD: in_ready = 1. Each byte is stored at the current index and XORed into the running checksum. After the byte at index 83, go to CHECK.
  - CHECK: in_ready = 1. If the received byte equals the running checksum, go to HOLD. Otherwise pulse err_code = 2 and go to IDLE.
  - HOLD: in_ready = 0, out_valid = 1. On out_ready, go to IDLE and increment stat_jobs.
- Timeout: a counter clears on every accepted byte and counts cycles while in PAYLOAD or CHECK. If it reaches TIMEOUT_CYCLES−1 in a cycle with no accepted byte, pulse err_code = 3 and go to IDLE. The counter is held at 0 in IDLE and HOLD.
- A SYNC_BYTE value inside PAYLOAD is ordinary data; there is no resynchronisation mid-frame.
- stat_jobs wraps from 16'hFFFF to 0.

## Timing
- Reset (rstn low, asynchronous): state = IDLE, in_ready = 1. All other outputs are 0: out_valid, out_* buses, err_valid, err_code, stat_jobs. Index, checksum and timeout counter are 0.
- Reset mid-frame or during HOLD drops the job immediately; no error is strobed.
- out_valid rises on the cycle after the checksum byte is accepted.
- out_valid falls on the cycle after the out_valid && out_ready handshake. in_ready is 1 in that same cycle.
- out_* bits stay stable for the whole HOLD interval.
- err_valid and err_code are registered. They assert on the cycle after the offending byte is accepted or the timeout threshold is reached, and hold for exactly one cycle.
- A byte accepted in the threshold cycle cancels the timeout; the byte wins.
- Throughput: one byte per cycle when in_valid is held high. The minimum frame-to-job latency is 86 accepted bytes plus 1 cycle.

## Test plan
- Golden frame: A5, P0..P83 = 0x00..0x53, C = XOR of the payload. Expect:
  - out_valid one cycle after C
  - out_data[7:0] = 8'h00 and out_state[31:24] = 8'h0C
  - out_position = 32'h4F4E4D4C and out_nonce_base = 32'h53525150
  - stat_jobs = 1 after out_ready
- Backpressure: hold out_ready = 0 for 500 cycles while in_valid stays high. Expect in_ready = 0 and out_* stable throughout. Pulse out_ready → in_ready = 1 on the next cycle and the next A5 is accepted.
- Corrupt checksum: flip bit 0 of C. Expect err_valid for one cycle with err_code = 2, out_valid never asserts, and an immediately following good frame is delivered.
- Junk before sync: send 3C, A5, then a valid frame. Expect one err_code = 1 pulse, then the job is delivered normally.
- Timeout: TIMEOUT_CYCLES = 16; stop after P40. Expect err_code = 3 exactly 16 cycles after P40 is accepted. Repeat with the next byte arriving in the threshold cycle → no error.
- Reset mid-HOLD: deassert rstn while out_valid = 1. Expect out_valid = 0 asynchronously, stat_jobs = 0, in_ready = 1.
